mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit_if.sv | 22 ++
 rtl/mc_control_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: memory request/ready handshake between the
// multicycle control unit (master) and the memory system (slave).
//   mem_req   : master -> slave, access request held until mem_ready
//   mem_write : master -> slave, request is a store
//   mem_ready : slave -> master, access completes this cycle
interface mc_control_unit_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS-style control FSM
// (FETCH/DECODE/EXEC/MEM/WB/HALT) with a saturating retired-instruction count.
// Ports:
//   clk, rst_b        : clock, async active-low reset
//   mem               : memory handshake (mem_req, mem_write, mem_ready)
//   opcode, func      : instruction register fields
//   zero              : ALU zero flag, gates the BEQ PC write
//   ir_we, pc_we, reg_we       : write enables
//   alu_src, reg_dest, link, pc_or_mem, mem_or_reg, branch : mux selects
//   alu_op            : 0=ADD, 1=SUB
//   halted, illegal   : sticky halt, one-cycle illegal-instruction pulse
//   instr_count       : retired instructions, saturating
module mc_control_unit #(
    parameter int OP_W    = 6,
    parameter int FUNC_W  = 6,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_b,
    mc_control_unit_if.master  mem,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNC_W-1:0]  func,
    input  logic               zero,
    output logic               ir_we,
    output logic               pc_we,
    output logic               reg_we,
    output logic               alu_src,
    output logic               reg_dest,
    output logic               link,
    output logic               pc_or_mem,
    output logic               mem_or_reg,
    output logic               branch,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);

    localparam logic [FUNC_W-1:0] F_ADD     = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] F_SYSCALL = FUNC_W'(6'b001100);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ADD,
        C_ADDI,
        C_LW,
        C_SW,
        C_BEQ,
        C_JAL,
        C_SYS,
        C_ILL
    } cls_t;

    state_t state_q, state_d;
    cls_t   cls_q, dec_cls;
    logic   r_type;
    logic   retire;
    logic [CNT_W-1:0] cnt_q;

    assign r_type = (opcode == OP_RTYPE);

    // Instruction class, sampled from the IR while in DECODE.
    always_comb begin
        dec_cls = C_ILL;
        unique case (1'b1)
            r_type && (func == F_ADD):     dec_cls = C_ADD;
            r_type && (func == F_SYSCALL): dec_cls = C_SYS;
            opcode == OP_ADDI:             dec_cls = C_ADDI;
            opcode == OP_LW:               dec_cls = C_LW;
            opcode == OP_SW:               dec_cls = C_SW;
            opcode == OP_BEQ:              dec_cls = C_BEQ;
            opcode == OP_JAL:              dec_cls = C_JAL;
            default:                       dec_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_FETCH;
            cls_q   <= C_ILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
            end
            if (retire && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs are gated by rst_b so an asserted reset drops every
    // enable and any pending mem_req in the same cycle, not at the
    // next clock edge.
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        reg_we        = 1'b0;
        alu_src       = 1'b0;
        reg_dest      = 1'b0;
        link          = 1'b0;
        pc_or_mem     = 1'b0;
        mem_or_reg    = 1'b0;
        branch        = 1'b0;
        alu_op        = ALU_ADD;
        halted        = 1'b0;
        illegal       = 1'b0;
        if (rst_b) begin
            unique case (state_q)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    unique case (dec_cls)
                        C_SYS: state_d = S_HALT;
                        C_ILL: begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    unique case (cls_q)
                        C_ADD: begin
                            reg_dest = 1'b1;
                            state_d  = S_WB;
                        end
                        C_ADDI: begin
                            alu_src = 1'b1;
                            state_d = S_WB;
                        end
                        C_LW, C_SW: begin
                            alu_src = 1'b1;
                            state_d = S_MEM;
                        end
                        C_BEQ: begin
                            alu_op  = ALU_SUB;
                            branch  = 1'b1;
                            pc_we   = zero;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        C_JAL: begin
                            link      = 1'b1;
                            pc_or_mem = 1'b1;
                            reg_we    = 1'b1;
                            pc_we     = 1'b1;
                            retire    = 1'b1;
                            state_d   = S_FETCH;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem.mem_req   = 1'b1;
                    mem.mem_write = (cls_q == C_SW);
                    if (mem.mem_ready) begin
                        if (cls_q == C_SW) begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    // reg_dest stays valid through the write for R-type.
                    reg_we     = 1'b1;
                    reg_dest   = (cls_q == C_ADD);
                    mem_or_reg = (cls_q == C_LW);
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed per-cycle checks of the control vector,
// ALU op and retired count of mc_control_unit, plus CNT_W=2 saturation.
module tb_mc_control_unit;

    localparam logic [12:0] MREQ  = 13'h1000;
    localparam logic [12:0] MWR   = 13'h0800;
    localparam logic [12:0] IRWE  = 13'h0400;
    localparam logic [12:0] PCWE  = 13'h0200;
    localparam logic [12:0] REGWE = 13'h0100;
    localparam logic [12:0] ASRC  = 13'h0080;
    localparam logic [12:0] RDST  = 13'h0040;
    localparam logic [12:0] LINK  = 13'h0020;
    localparam logic [12:0] PCM   = 13'h0010;
    localparam logic [12:0] MOR   = 13'h0008;
    localparam logic [12:0] BR    = 13'h0004;
    localparam logic [12:0] HLT   = 13'h0002;
    localparam logic [12:0] ILL   = 13'h0001;
    localparam logic [12:0] FTCH  = MREQ | IRWE | PCWE;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SYS   = 6'b001100;
    localparam logic [5:0] F_BAD   = 6'b000001;

    logic clk    = 1'b0;
    logic rst_b  = 1'b1;
    logic rst2_b = 1'b1;
    logic [5:0] opcode = OP_R;
    logic [5:0] func   = F_ADD;
    logic zero = 1'b0;

    logic ir_we, pc_we, reg_we, alu_src, reg_dest, link;
    logic pc_or_mem, mem_or_reg, branch, halted, illegal;
    logic [3:0]  alu_op;
    logic [31:0] instr_count;

    logic s_ir_we, s_pc_we, s_reg_we, s_alu_src, s_reg_dest, s_link;
    logic s_pc_or_mem, s_mem_or_reg, s_branch, s_halted, s_illegal;
    logic [3:0] s_alu_op;
    logic [1:0] s_instr_count;

    logic [12:0] ctl, ctl2;
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    mc_control_unit_if mif ();
    mc_control_unit_if mif2 ();

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk(clk), .rst_b(rst_b), .mem(mif),
        .opcode(opcode), .func(func), .zero(zero),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
        .alu_src(alu_src), .reg_dest(reg_dest), .link(link),
        .pc_or_mem(pc_or_mem), .mem_or_reg(mem_or_reg),
        .branch(branch), .alu_op(alu_op), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    mc_control_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_b(rst2_b), .mem(mif2),
        .opcode(opcode), .func(func), .zero(zero),
        .ir_we(s_ir_we), .pc_we(s_pc_we), .reg_we(s_reg_we),
        .alu_src(s_alu_src), .reg_dest(s_reg_dest), .link(s_link),
        .pc_or_mem(s_pc_or_mem), .mem_or_reg(s_mem_or_reg),
        .branch(s_branch), .alu_op(s_alu_op), .halted(s_halted),
        .illegal(s_illegal), .instr_count(s_instr_count)
    );

    assign ctl = {mif.mem_req, mif.mem_write, ir_we, pc_we, reg_we,
                  alu_src, reg_dest, link, pc_or_mem, mem_or_reg,
                  branch, halted, illegal};
    assign ctl2 = {mif2.mem_req, mif2.mem_write, s_ir_we, s_pc_we,
                   s_reg_we, s_alu_src, s_reg_dest, s_link,
                   s_pc_or_mem, s_mem_or_reg, s_branch, s_halted,
                   s_illegal};

    task automatic test_reset();
        mif.mem_ready = 1'b0;
        mif2.mem_ready = 1'b0;
        #1;
        rst_b = 1'b0;
        rst2_b = 1'b0;
        #1;
        checks++;
        if (ctl !== 13'h0 || alu_op !== 4'd0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: ctl=%h alu_op=%0d cnt=%0d, expected 0/0/0",
                     ctl, alu_op, instr_count);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ctl !== 13'h0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_held: ctl=%h cnt=%0d, expected 0/0", ctl, instr_count);
        end
        rst_b = 1'b1;
        exp_cnt = 0;
        #2;
        checks++;
        if (ctl !== MREQ) begin
            errors++;
            $display("FAIL first_fetch: ctl=%h, expected %h", ctl, MREQ);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        logic [12:0] e [4];
        e = '{FTCH, 13'h0, RDST, REGWE | RDST};
        opcode = OP_R;
        func = F_ADD;
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (ctl !== e[i] || alu_op !== 4'd0) begin
                errors++;
                $display("FAIL add cyc%0d: ctl=%h alu_op=%0d, expected ctl=%h alu_op=0",
                         i, ctl, alu_op, e[i]);
            end
            @(posedge clk);
            #1;
        end
        mif.mem_ready = 1'b0;
        exp_cnt++;
        checks++;
        if (instr_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL add_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_lw_wait();
        logic [12:0] e [11];
        logic        r [11];
        e = '{MREQ, MREQ, MREQ, FTCH, 13'h0, ASRC,
              MREQ, MREQ, MREQ, MREQ, REGWE | MOR};
        r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = OP_LW;
        for (int i = 0; i < 11; i++) begin
            mif.mem_ready = r[i];
            #2;
            checks++;
            if (ctl !== e[i] || alu_op !== 4'd0) begin
                errors++;
                $display("FAIL lw cyc%0d: ctl=%h alu_op=%0d, expected ctl=%h alu_op=0",
                         i, ctl, alu_op, e[i]);
            end
            @(posedge clk);
            #1;
        end
        mif.mem_ready = 1'b0;
        exp_cnt++;
        checks++;
        if (instr_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL lw_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_beq();
        logic [12:0] e [6];
        logic [3:0]  a [6];
        logic        z [6];
        e = '{FTCH, 13'h0, BR | PCWE, FTCH, 13'h0, BR};
        a = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1};
        z = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        opcode = OP_BEQ;
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            zero = z[i];
            #2;
            checks++;
            if (ctl !== e[i] || alu_op !== a[i]) begin
                errors++;
                $display("FAIL beq cyc%0d: ctl=%h alu_op=%0d, expected ctl=%h alu_op=%0d",
                         i, ctl, alu_op, e[i], a[i]);
            end
            @(posedge clk);
            #1;
        end
        mif.mem_ready = 1'b0;
        zero = 1'b0;
        exp_cnt += 2;
        checks++;
        if (instr_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL beq_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e [11];
        logic [5:0]  o [11];
        e = '{FTCH, 13'h0, ASRC, MREQ | MWR,
              FTCH, 13'h0, ASRC, REGWE,
              FTCH, 13'h0, LINK | PCM | REGWE | PCWE};
        o = '{OP_SW, OP_SW, OP_SW, OP_SW,
              OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
              OP_JAL, OP_JAL, OP_JAL};
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            opcode = o[i];
            #2;
            checks++;
            if (ctl !== e[i] || alu_op !== 4'd0) begin
                errors++;
                $display("FAIL b2b cyc%0d: ctl=%h alu_op=%0d, expected ctl=%h alu_op=0",
                         i, ctl, alu_op, e[i]);
            end
            @(posedge clk);
            #1;
        end
        mif.mem_ready = 1'b0;
        exp_cnt += 3;
        checks++;
        if (instr_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL b2b_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [12:0] e [6];
        logic [5:0]  o [6];
        logic        r [6];
        e = '{FTCH, ILL, MREQ, FTCH, ILL, MREQ};
        o = '{OP_BAD, OP_BAD, OP_BAD, OP_R, OP_R, OP_R};
        r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        func = F_BAD;
        for (int i = 0; i < 6; i++) begin
            opcode = o[i];
            mif.mem_ready = r[i];
            #2;
            checks++;
            if (ctl !== e[i]) begin
                errors++;
                $display("FAIL illegal cyc%0d: ctl=%h, expected %h", i, ctl, e[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instr_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL illegal_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
    endtask

    task automatic test_halt();
        opcode = OP_R;
        func = F_SYS;
        mif.mem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== FTCH) begin
            errors++;
            $display("FAIL sys_fetch: ctl=%h, expected %h", ctl, FTCH);
        end
        @(posedge clk);
        #3;
        checks++;
        if (ctl !== 13'h0) begin
            errors++;
            $display("FAIL sys_decode: ctl=%h, expected 0", ctl);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            mif.mem_ready = i[0];
            #2;
            checks++;
            if (ctl !== HLT || alu_op !== 4'd0) begin
                errors++;
                $display("FAIL halt cyc%0d: ctl=%h alu_op=%0d, expected ctl=%h",
                         i, ctl, alu_op, HLT);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instr_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL halt_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
        mif.mem_ready = 1'b0;
        rst_b = 1'b0;
        #1;
        checks++;
        if (ctl !== 13'h0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL halt_reset: ctl=%h cnt=%0d, expected 0/0", ctl, instr_count);
        end
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        #2;
        checks++;
        if (ctl !== MREQ) begin
            errors++;
            $display("FAIL halt_refetch: ctl=%h, expected %h", ctl, MREQ);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_access();
        logic [12:0] e [5];
        logic        r [5];
        e = '{FTCH, 13'h0, ASRC, MREQ | MWR, MREQ | MWR};
        r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = OP_SW;
        for (int i = 0; i < 5; i++) begin
            mif.mem_ready = r[i];
            #2;
            checks++;
            if (ctl !== e[i]) begin
                errors++;
                $display("FAIL sw_pend cyc%0d: ctl=%h, expected %h", i, ctl, e[i]);
            end
            if (i < 4) begin
                @(posedge clk);
                #1;
            end
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if (ctl !== 13'h0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL abandon: ctl=%h cnt=%0d, expected 0/0", ctl, instr_count);
        end
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        #2;
        checks++;
        if (ctl !== MREQ) begin
            errors++;
            $display("FAIL abandon_refetch: ctl=%h, expected %h", ctl, MREQ);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate();
        logic [1:0] s [5];
        s = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        opcode = OP_R;
        func = F_ADD;
        mif2.mem_ready = 1'b1;
        rst2_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (s_instr_count !== s[k]) begin
                errors++;
                $display("FAIL sat add%0d: cnt=%0d, expected %0d",
                         k + 1, s_instr_count, s[k]);
            end
        end
        #1;
        checks++;
        if (ctl2 !== FTCH || s_alu_op !== 4'd0) begin
            errors++;
            $display("FAIL sat_fetch: ctl=%h alu_op=%0d, expected %h/0",
                     ctl2, s_alu_op, FTCH);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_add();
        test_reset_mid_access();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
